// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard controller: stalls ID for DM_LAT cycles behind an EX load,
// then flags which operand(s) EX must take from DM read data.
module load_use_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int DM_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              flush,
    output logic              stall2,
    output logic              redir_dm2,
    output logic              redir_rs2,
    output logic              redir_rt2,
    output logic [CNT_W-1:0]  stall_events
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(DM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic              r_rs_f;
    logic              r_rt_f;
    logic [CNT_W-1:0]  r_events;

    logic w_ex_ld;
    logic w_hit_rs;
    logic w_hit_rt;
    logic w_hazard;
    logic w_detect;

    // A load to r0 never produces data anyone waits for.
    assign w_ex_ld  = ex_valid & ex_load & (ex_rd != '0);
    assign w_hit_rs = id_valid & id_use_rs & w_ex_ld & (id_rs == ex_rd);
    assign w_hit_rt = id_valid & id_use_rt & w_ex_ld & (id_rt == ex_rd);
    assign w_hazard = w_hit_rs | w_hit_rt;
    assign w_detect = (r_state == S_IDLE) & w_hazard & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_hazard) w_next = (DM_LAT > 1) ? S_HOLD : S_RELEASE;
                S_HOLD:    if (r_cnt == 3'd1) w_next = S_RELEASE;
                S_RELEASE: w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Operand flags are captured at detection; EX is a bubble afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 3'd0;
            r_rs_f   <= 1'b0;
            r_rt_f   <= 1'b0;
            r_events <= '0;
        end else if (flush) begin
            r_rs_f <= 1'b0;
            r_rt_f <= 1'b0;
        end else if (w_detect) begin
            r_cnt  <= LAT_M1;
            r_rs_f <= w_hit_rs;
            r_rt_f <= w_hit_rt;
            if (r_events != '1) r_events <= r_events + CNT_W'(1);
        end else if (r_state == S_HOLD) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    always_comb begin
        stall2    = 1'b0;
        redir_dm2 = 1'b0;
        redir_rs2 = 1'b0;
        redir_rt2 = 1'b0;
        if (!rst && !flush) begin
            case (r_state)
                S_IDLE:  stall2 = w_hazard;
                S_HOLD:  stall2 = 1'b1;
                S_RELEASE: begin
                    redir_dm2 = 1'b1;
                    redir_rs2 = r_rs_f;
                    redir_rt2 = r_rt_f;
                end
                default: stall2 = 1'b0;
            endcase
        end
    end

    assign stall_events = r_events;

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Bench for load_use_hazard_ctrl: three builds share one random input stream and
// are scored against a stall/redirect budget model through an expectation queue.
module tb_load_use_hazard_ctrl;

    localparam int N = 3;
    localparam int LAT[N] = '{1, 3, 7};
    localparam int CW[N]  = '{16, 4, 8};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic ex_valid = 1'b0, ex_load = 1'b0, flush = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;

    logic [N-1:0] st, rd, rs, rt;
    logic [15:0]  ev_a;
    logic [3:0]   ev_b;
    logic [7:0]   ev_c;
    logic [N-1:0][15:0] ev;
    assign ev[0] = ev_a;
    assign ev[1] = {12'd0, ev_b};
    assign ev[2] = {8'd0, ev_c};

    always #5 clk = ~clk;

    load_use_hazard_ctrl #(.REG_AW(5), .DM_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_valid(ex_valid),
        .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush), .stall2(st[0]),
        .redir_dm2(rd[0]), .redir_rs2(rs[0]), .redir_rt2(rt[0]), .stall_events(ev_a));
    load_use_hazard_ctrl #(.REG_AW(5), .DM_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_valid(ex_valid),
        .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush), .stall2(st[1]),
        .redir_dm2(rd[1]), .redir_rs2(rs[1]), .redir_rt2(rt[1]), .stall_events(ev_b));
    load_use_hazard_ctrl #(.REG_AW(5), .DM_LAT(7), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_valid(ex_valid),
        .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush), .stall2(st[2]),
        .redir_dm2(rd[2]), .redir_rs2(rs[2]), .redir_rt2(rt[2]), .stall_events(ev_c));

    typedef struct packed {
        logic [N-1:0]       st, rd, rs, rt;
        logic [N-1:0][15:0] ev;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: stall cycles still owed, a pending redirect, and a hazard tally.
    int left[N];
    bit pend[N], fr[N], ft[N];
    int evc[N];

    task automatic step(input bit r, f, iv, urs, urt, exv, exl,
                        input int rsv, rtv, rdv);
        exp_t e;
        bit hrs, hrt;
        @(negedge clk);
        rst = r; flush = f; id_valid = iv; id_use_rs = urs; id_use_rt = urt;
        ex_valid = exv; ex_load = exl;
        id_rs = 5'(rsv); id_rt = 5'(rtv); ex_rd = 5'(rdv);
        hrs = iv && urs && exv && exl && rdv != 0 && rsv == rdv;
        hrt = iv && urt && exv && exl && rdv != 0 && rtv == rdv;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                left[i] = 0; pend[i] = 0; fr[i] = 0; ft[i] = 0; evc[i] = 0;
                e.ev[i] = 16'd0;
            end else begin
                e.ev[i] = 16'(evc[i]);
                if (f) begin
                    left[i] = 0; pend[i] = 0; fr[i] = 0; ft[i] = 0;
                end else if (pend[i]) begin
                    e.rd[i] = 1'b1; e.rs[i] = fr[i]; e.rt[i] = ft[i];
                    pend[i] = 0;
                end else if (left[i] > 0) begin
                    e.st[i] = 1'b1;
                    left[i]--;
                    if (left[i] == 0) pend[i] = 1;
                end else if (hrs || hrt) begin
                    e.st[i] = 1'b1;
                    fr[i] = hrs; ft[i] = hrt;
                    if (evc[i] < (1 << CW[i]) - 1) evc[i]++;
                    left[i] = LAT[i] - 1;
                    if (left[i] == 0) pend[i] = 1;
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < N; i++) begin
                    tests++;
                    if (st[i] !== e.st[i] || rd[i] !== e.rd[i] || rs[i] !== e.rs[i] ||
                        rt[i] !== e.rt[i] || ev[i] !== e.ev[i]) begin
                        fails++;
                        $display("FAIL outputs lat%0d t=%0t got st=%b rd=%b rs=%b rt=%b ev=%0d want st=%b rd=%b rs=%b rt=%b ev=%0d",
                                 LAT[i], $time, st[i], rd[i], rs[i], rt[i], ev[i],
                                 e.st[i], e.rd[i], e.rs[i], e.rt[i], e.ev[i]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            left[i] = 0; pend[i] = 0; fr[i] = 0; ft[i] = 0; evc[i] = 0;
        end
        step(1, 0, 1, 1, 1, 1, 1, 5, 5, 5);   // hazard-looking inputs under reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // lw r5 ; add uses rs=r5
        step(0, 0, 1, 1, 0, 1, 1, 5, 3, 5);
        idle(9);
        // load to r0, and non-load writing r5
        step(0, 0, 1, 1, 1, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0, 5, 5, 5);
        idle(2);
        // rs = rt = r7
        step(0, 0, 1, 1, 1, 1, 1, 7, 7, 7);
        idle(9);
        // flush during hold
        step(0, 0, 1, 0, 1, 1, 1, 2, 9, 9);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(9);
        // reset mid-hold
        step(0, 0, 1, 1, 0, 1, 1, 4, 1, 4);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // back-to-back hazards, enough to saturate the 4-bit tally
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 1, 1, 0, 1, 1, 6, 0, 6);
            idle(8);
        end
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(199) == 0, $urandom_range(11) == 0,
                 $urandom_range(9) < 8, $urandom_range(9) < 7, $urandom_range(9) < 7,
                 $urandom_range(9) < 8, $urandom_range(1) == 1,
                 int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)));
        end
        idle(2);
        @(negedge clk);
        #5;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
